demux_1_4_stream: RTL
=====================

# demux_1_4_stream

- Routes a stream of 4-bit words to one of four output channels, chosen per word by a 2-bit select.
- Uses valid/ready handshakes on the input and on each output.
- Each output channel holds a one-entry registered buffer, so one stalled channel does not block words bound for the others once that channel's buffer is free.
- Sits at the distribution side of the 4:1 selection datapath: it fans out what the mux side gathers.

## Interface
- `WIDTH`, default 4: data width of the input and of each output channel.
- `CNT_W`, default 8: width of the per-channel delivery counters (used only with the configuration macro).
- `clk` input 1: single clock; every register updates on its rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: input word present.
- `in_ready` output 1: input word accepted this cycle when `in_valid` is also high.
- `in_data` input WIDTH: input word.
- `in_sel` input 2: destination channel 0..3 for `in_data`; sampled only while `in_valid` is high.
- `out_valid` output 4: bit k high means channel k holds a word.
- `out_ready` input 4: bit k high means channel k's consumer takes its word this cycle.
- `y0`, `y1`, `y2`, `y3` output WIDTH each: channel data, driven directly from the channel buffer register.
- `cnt0`..`cnt3` output CNT_W each: words delivered per channel.

## Operation
- Per channel k there is one buffer: flag `full[k]` and register `buf[k]`. `out_valid[k] = full[k]`. `yk = buf[k]`.
- Channel k drains when `full[k] && out_ready[k]`.
- `in_ready = !full[in_sel] || out_ready[in_sel]`. This is combinational on `in_sel` and `out_ready`, so the block accepts into a channel in the same cycle that channel drains.
- Acceptance is `in_valid && in_ready`. On acceptance:
  - `buf[in_sel]` loads `in_data`;
  - `full[in_sel]` is 1 next cycle.
- For any channel that drains without a write: `full[k]` goes to 0 and `buf[k]` holds its value.
- Simultaneous drain of channel k and write to channel k: `full[k]` stays 1, `buf[k]` takes the new word, and no bubble is inserted.
- Writes to one channel and drains of other channels are independent; all four channels may drain in the same cycle.
- Per-channel order is preserved. No word is dropped or duplicated.
- While `in_valid` is low, `in_ready` still reflects the current `in_sel` and has no side effect.
- Producer rule: once `in_valid` is raised with `in_ready` low, `in_valid`, `in_data` and `in_sel` must stay stable until acceptance. The bench checks this.
- Consumer rule: `out_valid[k]` and `yk` stay stable while `full[k]` is set and not drained.

## Timing
- Latency: a word accepted at edge N appears on `yk` with `out_valid[k]` high after edge N.
- Throughput: one word per cycle, sustained into any channel whose consumer keeps `out_ready[k]` high.
- Reset (`rst_n` low, asynchronous):
  - `full` = 0, so `out_valid` = 4'b0000;
  - `buf` = 0, so `y0`..`y3` = 0;
  - counters = 0.
- Reset mid-operation discards all buffered words immediately, without waiting for a clock edge.
- During reset `in_ready` evaluates to 1. No acceptance occurs until the first rising edge after `rst_n` deasserts.

## Configuration
- Macro: `DEMUX_1_4_STREAM_CNT_EN`.
- Defined:
  - `cntk` increments by 1 on every drain of channel k;
  - it saturates at 2^CNT_W−1 and does not wrap;
  - it resets to 0.
- Undefined: the counter logic is not built. `cnt0`..`cnt3` are tied to 0 and the port list is unchanged.

## Test plan
- Reset, then `in_valid`=1, `in_sel`=2, `in_data`=4'hA, `out_ready`=4'b0000 → next cycle `out_valid`=4'b0100, `y2`=4'hA, and `in_ready`=0 while `in_sel` stays 2.
- Channel 2 full with `out_ready[2]`=1, new word 4'h5 to `in_sel`=2 in the same cycle → `in_ready`=1, next cycle `out_valid[2]`=1, `y2`=4'h5, no bubble.
- Channel 0 stalled (`out_ready[0]`=0, full with 4'h3), words 4'h1/4'h2/4'h4 sent to channels 1/2/3 → each accepted in consecutive cycles, `y0` holds 4'h3 throughout.
- Streaming 16 words 0..F to channel 3 with `out_ready[3]` toggling pseudo-randomly → consumer sees 0..F in order, none lost or duplicated.
- `rst_n` pulsed low between clock edges while channels 1 and 3 are full → `out_valid` goes to 4'b0000 immediately, before the next edge.
- With `DEMUX_1_4_STREAM_CNT_EN` defined, `CNT_W`=4, 20 drains on channel 1 → `cnt1`=15 (saturated), other counters 0. Without the macro → all `cnt` outputs 0.

Source files
------------

// File: rtl/demux_1_4_stream.sv
// 1:4 stream demux. Each output channel has a one-entry registered buffer.
// Optional per-channel delivery counters are enabled by DEMUX_1_4_STREAM_CNT_EN.
module demux_1_4_stream_chan #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rdy,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);
  logic drain;
  assign drain = full && rdy;

  // When a write and a drain land on the same edge, the write wins and full stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (wr) begin
      full <= 1'b1;
      data <= wdata;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

`ifdef DEMUX_1_4_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (drain && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end
`else
  assign cnt = '0;
`endif
endmodule

module demux_1_4_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0]            full;
  logic [NUM_LANES-1:0]            wr;
  logic [NUM_LANES-1:0][WIDTH-1:0] data;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
  logic                            accept;

  // Ready looks through to the selected channel's consumer so a draining buffer refills without a bubble.
  assign in_ready = !full[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign wr[k] = accept && (in_sel == 2'(k));
      demux_1_4_stream_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr[k]),
        .wdata (in_data),
        .rdy   (out_ready[k]),
        .full  (full[k]),
        .data  (data[k]),
        .cnt   (cnt[k])
      );
    end
  endgenerate

  assign out_valid = full;
  assign y0   = data[0];
  assign y1   = data[1];
  assign y2   = data[2];
  assign y3   = data[3];
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
endmodule
